// File: rtl/sd_pkg.sv
// Shared SD command-path definitions: receiver states, frame geometry and CRC7 constants.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_RECV,
    ST_DONE
  } rx_state_e;

  localparam int SD_RESP_LEN = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Frame bit positions, 47 = start bit down to 0 = end bit.
  localparam int IDX_HI = 45;
  localparam int IDX_LO = 40;
  localparam int ARG_HI = 39;
  localparam int ARG_LO = 8;
  localparam int CRC_HI = 7;
  localparam int CRC_LO = 1;

  // Bit-counter values inside RECV (start bit excluded).
  localparam logic [5:0] TX_BIT_N   = 6'd1;
  localparam logic [5:0] CRC_LAST_N = 6'd39;
  localparam logic [5:0] END_BIT_N  = 6'd47;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial MSB-first CRC7 (x^7+x^3+1), shared by the command transmit and receive paths.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       valid,
  input  logic       data,
  output logic [6:0] crc
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every reader sees the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (valid) begin
      crc <= crc7_step(crc, data);
    end
  end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line 48-bit response receiver: start-bit hunt with Ncr timeout,
// deserialization, CRC7 check and framing checks, reported with a done pulse.
module sd_cmd_resp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_en,
  input  logic        cmd_i,
  input  logic        arm_i,
  input  logic        crc_chk_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  resp_index_o,
  output logic [31:0] resp_arg_o,
  output logic [6:0]  resp_crc_o,
  output logic        crc_err_o,
  output logic        frame_err_o,
  output logic        timeout_o
);

  localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);
  // Holds frame bits [45:1]; data_q[k-1] is frame bit k once the end bit arrives.
  localparam int DATA_W = SD_RESP_LEN - 3;

  rx_state_e         state;
  logic [5:0]        bit_cnt;
  logic [7:0]        wait_cnt;
  logic [DATA_W-1:0] data_q;
  logic              chk_en_q;

  logic              crc_clear;
  logic              crc_valid;
  logic [6:0]        crc_calc;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    crc_clear = 1'b0;
    crc_valid = 1'b0;
    if (state == ST_IDLE && arm_i) begin
      crc_clear = 1'b1;
    end
    if (bit_en) begin
      if (state == ST_HUNT && !cmd_i) begin
        crc_valid = 1'b1;
      end else if (state == ST_RECV && bit_cnt <= CRC_LAST_N) begin
        crc_valid = 1'b1;
      end
    end
  end

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .valid (crc_valid),
    .data  (cmd_i),
    .crc   (crc_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      data_q       <= '0;
      chk_en_q     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      resp_index_o <= '0;
      resp_arg_o   <= '0;
      resp_crc_o   <= '0;
      crc_err_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (arm_i) begin
            chk_en_q    <= crc_chk_en_i;
            wait_cnt    <= '0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
            timeout_o   <= 1'b0;
            busy_o      <= 1'b1;
            state       <= ST_HUNT;
          end
        end

        ST_HUNT: begin
          if (bit_en) begin
            if (!cmd_i) begin
              bit_cnt <= 6'd1;
              state   <= ST_RECV;
            end else if (wait_cnt == NCR_LAST) begin
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state     <= ST_DONE;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end

        ST_RECV: begin
          if (bit_en) begin
            if (bit_cnt == TX_BIT_N && cmd_i) begin
              frame_err_o <= 1'b1;
            end
            if (bit_cnt == END_BIT_N) begin
              // The end bit is checked directly and never enters data_q.
              if (!cmd_i) begin
                frame_err_o <= 1'b1;
              end
              if (chk_en_q && (data_q[CRC_HI-1:CRC_LO-1] != crc_calc)) begin
                crc_err_o <= 1'b1;
              end
              resp_index_o <= data_q[IDX_HI-1:IDX_LO-1];
              resp_arg_o   <= data_q[ARG_HI-1:ARG_LO-1];
              resp_crc_o   <= data_q[CRC_HI-1:CRC_LO-1];
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
              state        <= ST_DONE;
            end else begin
              data_q  <= {data_q[DATA_W-2:0], cmd_i};
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        ST_DONE: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Directed bench for sd_cmd_resp_rx using known-good SD response frames.
module tb_sd_cmd_resp_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_en;
  logic        cmd_i;
  logic        arm_i;
  logic        crc_chk_en_i;
  logic        busy_o;
  logic        done_o;
  logic [5:0]  resp_index_o;
  logic [31:0] resp_arg_o;
  logic [6:0]  resp_crc_o;
  logic        crc_err_o;
  logic        frame_err_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  int done_before;

  // {index byte, argument, CRC7, end bit}
  localparam logic [47:0] F_CMD17 = {8'h11, 32'h0000_0900, 7'h33, 1'b1};
  localparam logic [47:0] F_BIT20 = F_CMD17 ^ (48'h1 << 20);
  localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
  localparam logic [47:0] F_R3    = {8'h3F, 32'h80FF_8000, 7'h7F, 1'b1};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && done_o) done_seen <= done_seen + 1;
  end

  sd_cmd_resp_rx #(.NCR_MAX(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_en       (bit_en),
    .cmd_i        (cmd_i),
    .arm_i        (arm_i),
    .crc_chk_en_i (crc_chk_en_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .resp_index_o (resp_index_o),
    .resp_arg_o   (resp_arg_o),
    .resp_crc_o   (resp_crc_o),
    .crc_err_o    (crc_err_o),
    .frame_err_o  (frame_err_o),
    .timeout_o    (timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic chk);
    arm_i = 1'b1;
    crc_chk_en_i = chk;
    tick();
    arm_i = 1'b0;
    crc_chk_en_i = ~chk;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int g = 1; g < gap; g++) tick();
    cmd_i  = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    cmd_i  = 1'b1;
  endtask

  task automatic send_bits(input logic [47:0] f, input int hi, input int lo, input bit rnd);
    for (int i = hi; i >= lo; i--) send_bit(f[i], rnd ? int'($urandom_range(1, 5)) : 1);
  endtask

  task automatic check_result(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                              input logic [6:0] crc, input logic cerr, input logic ferr);
    check({tag, ".done"}, 64'(done_o), 64'd1);
    check({tag, ".busy"}, 64'(busy_o), 64'd0);
    check({tag, ".index"}, 64'(resp_index_o), 64'(idx));
    check({tag, ".arg"}, 64'(resp_arg_o), 64'(arg));
    check({tag, ".crc"}, 64'(resp_crc_o), 64'(crc));
    check({tag, ".crc_err"}, 64'(crc_err_o), 64'(cerr));
    check({tag, ".frame_err"}, 64'(frame_err_o), 64'(ferr));
    check({tag, ".timeout"}, 64'(timeout_o), 64'd0);
    tick();
    check({tag, ".done_low"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bit_en = 1'b0;
    cmd_i = 1'b1;
    arm_i = 1'b0;
    crc_chk_en_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst.busy", 64'(busy_o), 64'd0);
    check("rst.done", 64'(done_o), 64'd0);
    check("rst.index", 64'(resp_index_o), 64'd0);
    check("rst.arg", 64'(resp_arg_o), 64'd0);
    check("rst.flags", 64'({crc_err_o, frame_err_o, timeout_o}), 64'd0);

    // Valid CMD17 R1 response
    arm(1'b1);
    check("cmd17.busy_rise", 64'(busy_o), 64'd1);
    send_bits(F_CMD17, 47, 0, 1'b0);
    check_result("cmd17", 6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0);

    // Bit 20 flipped: payload corrupt, framing intact
    arm(1'b1);
    send_bits(F_BIT20, 47, 0, 1'b0);
    check_result("bit20", 6'h11, 32'h0000_1900, 7'h33, 1'b1, 1'b0);

    // Host-direction frame: transmission bit 1, CRC consistent
    arm(1'b1);
    send_bits(F_CMD0, 47, 0, 1'b0);
    check_result("cmd0", 6'h00, 32'h0000_0000, 7'h4A, 1'b0, 1'b1);

    // R3 carries all-ones CRC field; check disabled then enabled
    arm(1'b0);
    send_bits(F_R3, 47, 0, 1'b0);
    check_result("r3_nochk", 6'h3F, 32'h80FF_8000, 7'h7F, 1'b0, 1'b0);
    arm(1'b1);
    send_bits(F_R3, 47, 0, 1'b0);
    check_result("r3_chk", 6'h3F, 32'h80FF_8000, 7'h7F, 1'b1, 1'b0);

    // Ncr timeout: 63 high samples keep hunting, the 64th ends it
    arm(1'b1);
    for (int i = 0; i < 63; i++) send_bit(1'b1, 1);
    check("to.done_early", 64'(done_o), 64'd0);
    check("to.busy_early", 64'(busy_o), 64'd1);
    send_bit(1'b1, 1);
    check("to.done", 64'(done_o), 64'd1);
    check("to.timeout", 64'(timeout_o), 64'd1);
    check("to.busy", 64'(busy_o), 64'd0);
    check("to.index_hold", 64'(resp_index_o), 64'h3F);
    check("to.arg_hold", 64'(resp_arg_o), 64'h80FF_8000);
    check("to.errs", 64'({crc_err_o, frame_err_o}), 64'd0);
    tick();
    check("to.done_low", 64'(done_o), 64'd0);

    // Arm coincident with a low strobe (not consumed), then 20 idle bits
    arm_i = 1'b1;
    crc_chk_en_i = 1'b1;
    bit_en = 1'b1;
    cmd_i = 1'b0;
    tick();
    arm_i = 1'b0;
    bit_en = 1'b0;
    cmd_i = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1);
    check("pre.busy", 64'(busy_o), 64'd1);
    send_bits(F_CMD17, 47, 0, 1'b0);
    check_result("pre", 6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0);

    // Reset after 25 bits aborts silently; re-armed frame with jittered strobes completes
    arm(1'b1);
    send_bits(F_BIT20, 47, 23, 1'b1);
    done_before = done_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", 64'(busy_o), 64'd0);
    check("abort.done", 64'(done_o), 64'd0);
    repeat (5) tick();
    check("abort.no_done", 64'(done_seen), 64'(done_before));
    check("abort.arg_reset", 64'(resp_arg_o), 64'd0);
    arm(1'b1);
    send_bits(F_CMD17, 47, 0, 1'b1);
    check_result("rearm", 6'h11, 32'h0000_0900, 7'h33, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
